// File: rtl/serial_tx_if.sv
// Host-side byte stream interface of the UART transmitter.
//   block        host -> tx   hold off new frames
//   tx_busy      tx -> host   high while new_tx_data would be ignored
//   tx_data      host -> tx   byte to send, sampled on acceptance
//   new_tx_data  host -> tx   single-cycle transmit request
//   tx           tx -> line   serial output, idles high
interface serial_tx_if;
  logic       block;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx;

  modport master (
    output block,
    output tx_data,
    output new_tx_data,
    input  tx_busy,
    input  tx
  );

  modport slave (
    input  block,
    input  tx_data,
    input  new_tx_data,
    output tx_busy,
    output tx
  );
endinterface

// File: rtl/serial_tx.sv
// UART transmitter: latches a byte on new_tx_data and shifts out
// start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// tx_busy covers both an in-flight frame and host-requested hold-off.
//   clk    system clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    serial_tx_if.slave (block, tx_busy, tx_data, new_tx_data, tx)
module serial_tx #(
  parameter int unsigned CLK_PER_BIT = 100,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_tx_if.slave  bus
);

  localparam int unsigned CTR_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX   = CTR_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  // Reject unsupported configurations at elaboration.
  if (CLK_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY > 2) begin : g_bad_params
    $error("serial_tx: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_d;
  logic [CTR_W-1:0] ctr, ctr_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d;
  logic             par_bit, par_bit_d;
  logic             tx_q, tx_d;
  logic             block_q;
  logic             bit_end;

  assign bit_end     = (ctr == CTR_MAX);
  assign bus.tx_busy = block_q | (state != S_IDLE);
  assign bus.tx      = tx_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ctr     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx_q    <= 1'b1;
      block_q <= 1'b0;
    end else begin
      state   <= state_d;
      ctr     <= ctr_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      par_bit <= par_bit_d;
      tx_q    <= tx_d;
      block_q <= bus.block;
    end
  end

  // Next-state, bit timing and line value.
  always_comb begin
    state_d   = state;
    ctr_d     = ctr;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    par_bit_d = par_bit;
    tx_d      = 1'b1;

    if (state == S_IDLE) begin
      ctr_d     = '0;
      bit_idx_d = '0;
    end else begin
      ctr_d = bit_end ? '0 : ctr + CTR_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (!block_q && bus.new_tx_data) begin
          state_d = S_START;
          shift_d = bus.tx_data;
          if (PARITY == 0) begin
            par_bit_d = 1'b0;
          end else if (PARITY == 1) begin
            par_bit_d = ~^bus.tx_data;
          end else begin
            par_bit_d = ^bus.tx_data;
          end
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // bit_idx counts stop bits here.
        if (bit_end) begin
          if (bit_idx == LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line value follows the next state so tx is aligned with it from a register.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule
